// File: rtl/tcam_key_match.sv
// Snoops an AXI-Stream, extracts a 32-bit key from eligible UDP packets, matches it against a
// small valid-qualified key table and issues one hit/miss strobe per packet. Optional: TCAM_HIT_CNT_EN.
`timescale 1ns/1ps

`ifndef IPPROT_UDP
`define IPPROT_UDP 8'h11
`endif
`ifndef DST_PORT
`define DST_PORT 16'h12b5
`endif

module tcam_key_match #(
  parameter int C_S_AXIS_DATA_WIDTH = 256,
  parameter int KEY_WIDTH           = 32,
  parameter int TCAM_MATCH_ADDR     = 5,
  parameter int RESULT_DEPTH        = 4
) (
  input  logic                           axis_aclk,
  input  logic                           axis_resetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                           s_axis_tvalid,
  input  logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  input  logic                           cfg_wr_en,
  input  logic [TCAM_MATCH_ADDR-1:0]     cfg_addr,
  input  logic [KEY_WIDTH-1:0]           cfg_key,
  input  logic                           cfg_entry_valid,
  input  logic                           i_flush_ready,
  output logic                           o_tcam_match,
  output logic                           o_tcam_match_end,
  output logic                           o_result_ovf
`ifdef TCAM_HIT_CNT_EN
  ,
  output logic [31:0]                    o_hit_cnt,
  output logic [31:0]                    o_miss_cnt
`endif
);

  localparam int N_ENTRIES = 1 << TCAM_MATCH_ADDR;
  localparam int KEY_LSB   = 192;
  localparam int PTR_W     = (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1;
  localparam int CNT_W     = $clog2(RESULT_DEPTH + 1);

  typedef enum logic [1:0] {
    P_IDLE,
    P_HDR2,
    P_BODY,
    P_SKIP
  } parse_state_t;

  parse_state_t           r_state;
  logic [KEY_WIDTH-1:0]   r_key;
  logic                   r_proto_ok;
  logic                   r_lookup_pending;
  logic                   r_hit;

  logic [KEY_WIDTH-1:0]   r_tbl_key [N_ENTRIES];
  logic [N_ENTRIES-1:0]   r_tbl_valid;

  logic                   r_q_mem [RESULT_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic                   r_ovf;
  logic                   r_match;
  logic                   r_match_end;

  logic                   w_accept;
  logic                   w_beat1_elig;
  logic                   w_lookup_hit;
  logic                   w_push;
  logic                   w_push_hit;
  logic                   w_push_ok;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_unused_tdata;

  assign w_accept     = s_axis_tvalid & s_axis_tready;
  assign w_beat1_elig = r_proto_ok && (s_axis_tdata[47:32] == `DST_PORT);
  assign w_full       = (r_count == CNT_W'(RESULT_DEPTH));
  assign w_empty      = (r_count == '0);

  assign w_unused_tdata = ^{s_axis_tdata[C_S_AXIS_DATA_WIDTH-1:KEY_LSB+KEY_WIDTH],
                            s_axis_tdata[183:48], s_axis_tdata[31:0]};

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(RESULT_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // Only the hit bit leaves the block, so the lowest-index priority collapses to an OR of all
  // matching valid entries. Reads the registered table, so a same-cycle write is not yet visible.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_lookup_hit = 1'b0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (r_tbl_valid[i] && (r_tbl_key[i] == r_key)) w_lookup_hit = 1'b1;
    end
  end

  // A packet ending on beat1 pushes the lookup that is still in flight that same cycle.
  always_comb begin
    w_push     = 1'b0;
    w_push_hit = r_lookup_pending ? w_lookup_hit : r_hit;
    if (w_accept && s_axis_tlast) begin
      case (r_state)
        P_HDR2:  w_push = w_beat1_elig;
        P_BODY:  w_push = 1'b1;
        default: w_push = 1'b0;
      endcase
    end
  end

  // The previous issue blocks the following cycle, spacing results at least two cycles apart.
  assign w_pop     = !w_empty && i_flush_ready && !r_match_end;
  assign w_push_ok = w_push && (!w_full || w_pop);

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_state          <= P_IDLE;
      r_key            <= '0;
      r_proto_ok       <= 1'b0;
      r_lookup_pending <= 1'b0;
      r_hit            <= 1'b0;
    end else begin
      r_lookup_pending <= 1'b0;
      if (r_lookup_pending) r_hit <= w_lookup_hit;
      if (w_accept) begin
        case (r_state)
          P_IDLE: begin
            if (!s_axis_tlast) begin
              r_state          <= P_HDR2;
              r_key            <= s_axis_tdata[KEY_LSB +: KEY_WIDTH];
              r_proto_ok       <= (s_axis_tdata[191:184] == `IPPROT_UDP);
              r_lookup_pending <= 1'b1;
            end
          end
          P_HDR2: begin
            if (s_axis_tlast)      r_state <= P_IDLE;
            else if (w_beat1_elig) r_state <= P_BODY;
            else                   r_state <= P_SKIP;
          end
          P_BODY, P_SKIP: begin
            if (s_axis_tlast) r_state <= P_IDLE;
          end
          default: r_state <= P_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_tbl_valid <= '0;
    end else if (cfg_wr_en) begin
      r_tbl_valid[cfg_addr] <= cfg_entry_valid;
    end
  end

  // NOTE: storage arrays are left unreset; the valid bits and queue count qualify every read.
  always_ff @(posedge axis_aclk) begin
    if (cfg_wr_en) r_tbl_key[cfg_addr] <= cfg_key;
  end

  always_ff @(posedge axis_aclk) begin
    if (w_push_ok) r_q_mem[r_wr_ptr] <= w_push_hit;
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok)           r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_pop)               r_rd_ptr <= ptr_next(r_rd_ptr);
      if (w_push && !w_push_ok) r_ovf   <= 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_match_end <= 1'b0;
      r_match     <= 1'b0;
    end else begin
      r_match_end <= w_pop;
      r_match     <= w_pop & r_q_mem[r_rd_ptr];
    end
  end

  assign o_tcam_match     = r_match;
  assign o_tcam_match_end = r_match_end;
  assign o_result_ovf     = r_ovf;

`ifdef TCAM_HIT_CNT_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // Counted at pop time so each count lands together with its result strobe.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_pop) begin
      if (r_q_mem[r_rd_ptr]) begin
        if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
      end else begin
        if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign o_hit_cnt  = r_hit_cnt;
  assign o_miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_tcam_key_match.sv
// Scoreboard bench for tcam_key_match: directed packets push expected results, a negedge
// monitor pops and compares on every o_tcam_match_end strobe.
`timescale 1ns/1ps

module tb_tcam_key_match;

  localparam logic [7:0]  PROTO_UDP = 8'h11;
  localparam logic [7:0]  PROTO_TCP = 8'h06;
  localparam logic [15:0] PORT_OK   = 16'h12b5;
  localparam logic [15:0] PORT_BAD  = 16'h0035;
  localparam logic [31:0] KEY_A     = 32'h0A00_0001;
  localparam logic [31:0] KEY_B     = 32'h0A00_0002;
  localparam logic [31:0] KEY_C     = 32'h0A00_0005;

  logic         axis_aclk = 1'b0;
  logic         axis_resetn;
  logic [255:0] s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic         cfg_wr_en;
  logic [4:0]   cfg_addr;
  logic [31:0]  cfg_key;
  logic         cfg_entry_valid;
  logic         i_flush_ready;
  logic         o_tcam_match;
  logic         o_tcam_match_end;
  logic         o_result_ovf;
`ifdef TCAM_HIT_CNT_EN
  logic [31:0]  o_hit_cnt;
  logic [31:0]  o_miss_cnt;
`endif

  tcam_key_match dut (
    .axis_aclk        (axis_aclk),
    .axis_resetn      (axis_resetn),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tlast     (s_axis_tlast),
    .cfg_wr_en        (cfg_wr_en),
    .cfg_addr         (cfg_addr),
    .cfg_key          (cfg_key),
    .cfg_entry_valid  (cfg_entry_valid),
    .i_flush_ready    (i_flush_ready),
    .o_tcam_match     (o_tcam_match),
    .o_tcam_match_end (o_tcam_match_end),
    .o_result_ovf     (o_result_ovf)
`ifdef TCAM_HIT_CNT_EN
    ,
    .o_hit_cnt        (o_hit_cnt),
    .o_miss_cnt       (o_miss_cnt)
`endif
  );

  always #5 axis_aclk = ~axis_aclk;

  int cyc = 0;
  always @(posedge axis_aclk) cyc <= cyc + 1;

  typedef struct {
    logic hit;
    int   cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks   = 0;
  int   n_errors   = 0;
  int   last_pulse = -100;
  int   drv_cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest expected result.
  always @(negedge axis_aclk) begin
    if (axis_resetn === 1'b1) begin
      if (o_tcam_match_end) begin
        check("pulse_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check("match_value", 32'(o_tcam_match), 32'(mon_e.hit));
          if (mon_e.cyc >= 0) check("match_latency", cyc, mon_e.cyc);
        end
        check("issue_gap", 32'((cyc - last_pulse) >= 2), 32'd1);
        last_pulse = cyc;
      end else begin
        check("match_qualified", 32'(o_tcam_match), 32'd0);
      end
    end
  end

  task automatic drive(input logic v, input logic [255:0] d, input logic l, input logic rdy,
                       input logic we, input logic [4:0] a, input logic [31:0] k,
                       input logic ev);
    @(negedge axis_aclk);
    drv_cyc         = cyc;
    s_axis_tvalid   = v;
    s_axis_tdata    = d;
    s_axis_tlast    = l;
    s_axis_tready   = rdy;
    cfg_wr_en       = we;
    cfg_addr        = a;
    cfg_key         = k;
    cfg_entry_valid = ev;
    @(posedge axis_aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    cfg_wr_en     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [31:0] k, input logic ev);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1, a, k, ev);
  endtask

  function automatic logic [255:0] beat0(input logic [7:0] proto, input logic [31:0] key);
    logic [255:0] d = '0;
    d[191:184] = proto;
    d[223:192] = key;
    return d;
  endfunction

  function automatic logic [255:0] beat1(input logic [15:0] port);
    logic [255:0] d = '0;
    d[47:32] = port;
    return d;
  endfunction

  // stall inserts a tlast beat with tready low after beat0, which must not be accepted.
  task automatic send_pkt(input logic [31:0] key, input logic [7:0] proto, input logic [15:0] port,
                          input int nbeats, input logic stall, input logic exp_push,
                          input logic exp_hit, input logic timed);
    logic [255:0] d;
    for (int i = 0; i < nbeats; i++) begin
      if (i == 0)      d = beat0(proto, key);
      else if (i == 1) d = beat1(port);
      else             d = {8{32'hC0DE_0000 | 32'(i)}};
      drive(1'b1, d, (i == nbeats - 1), 1'b1, 1'b0, '0, '0, 1'b0);
      if (i == 0 && stall) drive(1'b1, '1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    end
    if (exp_push) sb.push_back('{hit: exp_hit, cyc: (timed ? drv_cyc + 2 : -1)});
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge axis_aclk);
    check("scoreboard_drained", sb.size(), 32'd0);
    idle(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    axis_resetn     = 1'b0;
    s_axis_tdata    = '0;
    s_axis_tvalid   = 1'b0;
    s_axis_tready   = 1'b1;
    s_axis_tlast    = 1'b0;
    cfg_wr_en       = 1'b0;
    cfg_addr        = '0;
    cfg_key         = '0;
    cfg_entry_valid = 1'b0;
    i_flush_ready   = 1'b1;
    repeat (3) @(negedge axis_aclk);
    check("rst_match", 32'(o_tcam_match), 32'd0);
    check("rst_match_end", 32'(o_tcam_match_end), 32'd0);
    check("rst_ovf", 32'(o_result_ovf), 32'd0);
    axis_resetn = 1'b1;
    idle(2);

    // Entry 9 duplicates entry 3 so a multi-hit lookup is exercised.
    cfg_write(5'd3, KEY_A, 1'b1);
    cfg_write(5'd5, KEY_C, 1'b1);
    cfg_write(5'd9, KEY_A, 1'b1);

    // Basic hit / miss with exact latency.
    send_pkt(KEY_A, PROTO_UDP, PORT_OK, 4, 1'b0, 1'b1, 1'b1, 1'b1);
    drain();
    send_pkt(KEY_B, PROTO_UDP, PORT_OK, 4, 1'b0, 1'b1, 1'b0, 1'b1);
    drain();

    // Ineligible packets: no strobe may appear.
    send_pkt(KEY_A, PROTO_TCP, PORT_OK, 4, 1'b0, 1'b0, 1'b0, 1'b0);
    send_pkt(KEY_A, PROTO_UDP, PORT_BAD, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    send_pkt(KEY_A, PROTO_UDP, PORT_OK, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(6);

    // Packet ending on beat1, and one with an unaccepted stall beat.
    send_pkt(KEY_C, PROTO_UDP, PORT_OK, 2, 1'b0, 1'b1, 1'b1, 1'b1);
    drain();
    send_pkt(KEY_B, PROTO_UDP, PORT_OK, 3, 1'b1, 1'b1, 1'b0, 1'b1);
    drain();

    // Back-to-back packets: beat0 arrives while the previous result is queued.
    send_pkt(KEY_A, PROTO_UDP, PORT_OK, 3, 1'b0, 1'b1, 1'b1, 1'b1);
    send_pkt(KEY_B, PROTO_UDP, PORT_OK, 3, 1'b0, 1'b1, 1'b0, 1'b1);
    send_pkt(KEY_C, PROTO_UDP, PORT_OK, 3, 1'b0, 1'b1, 1'b1, 1'b1);
    drain();

    // Queue overflow with the flush stage busy, then in-order release.
    @(negedge axis_aclk);
    i_flush_ready = 1'b0;
    send_pkt(KEY_A, PROTO_UDP, PORT_OK, 3, 1'b0, 1'b1, 1'b1, 1'b0);
    send_pkt(KEY_B, PROTO_UDP, PORT_OK, 3, 1'b0, 1'b1, 1'b0, 1'b0);
    send_pkt(KEY_C, PROTO_UDP, PORT_OK, 3, 1'b0, 1'b1, 1'b1, 1'b0);
    send_pkt(KEY_A, PROTO_UDP, PORT_OK, 3, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);
    check("ovf_at_full", 32'(o_result_ovf), 32'd0);
    send_pkt(KEY_B, PROTO_UDP, PORT_OK, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("ovf_after_drop", 32'(o_result_ovf), 32'd1);
    @(negedge axis_aclk);
    i_flush_ready = 1'b1;
    drain();
    check("ovf_sticky", 32'(o_result_ovf), 32'd1);

    // Invalidating entry 3 during the lookup cycle still hits; the next packet misses.
    cfg_write(5'd9, KEY_A, 1'b0);
    drive(1'b1, beat0(PROTO_UDP, KEY_A), 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
    drive(1'b1, beat1(PORT_OK), 1'b0, 1'b1, 1'b1, 5'd3, KEY_A, 1'b0);
    drive(1'b1, '0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
    sb.push_back('{hit: 1'b1, cyc: drv_cyc + 2});
    drain();
    send_pkt(KEY_A, PROTO_UDP, PORT_OK, 3, 1'b0, 1'b1, 1'b0, 1'b1);
    drain();

    // Reset during beat 2 of an eligible packet.
    cfg_write(5'd3, KEY_A, 1'b1);
    drive(1'b1, beat0(PROTO_UDP, KEY_A), 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
    drive(1'b1, beat1(PORT_OK), 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
    @(negedge axis_aclk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    #2;
    axis_resetn = 1'b0;
    #1;
    check("rst_mid_match", 32'(o_tcam_match), 32'd0);
    check("rst_mid_match_end", 32'(o_tcam_match_end), 32'd0);
    check("rst_mid_ovf", 32'(o_result_ovf), 32'd0);
    @(posedge axis_aclk);
    #1;
    s_axis_tvalid = 1'b0;
    repeat (2) @(negedge axis_aclk);
    axis_resetn = 1'b1;
    // Leftover tlast beat is now a single-beat packet: no result.
    drive(1'b1, '0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
    idle(4);
    // Table was cleared: same key now misses, then hits once rewritten.
    send_pkt(KEY_A, PROTO_UDP, PORT_OK, 3, 1'b0, 1'b1, 1'b0, 1'b1);
    drain();
    cfg_write(5'd3, KEY_A, 1'b1);
    send_pkt(KEY_A, PROTO_UDP, PORT_OK, 3, 1'b0, 1'b1, 1'b1, 1'b1);
    drain();

    // Since reset: 1 miss, 1 hit so far; bring the totals to 3 hits and 2 misses.
    send_pkt(KEY_A, PROTO_UDP, PORT_OK, 3, 1'b0, 1'b1, 1'b1, 1'b1);
    send_pkt(KEY_B, PROTO_UDP, PORT_OK, 3, 1'b0, 1'b1, 1'b0, 1'b1);
    send_pkt(KEY_A, PROTO_UDP, PORT_OK, 4, 1'b0, 1'b1, 1'b1, 1'b1);
    drain();
    check("ovf_after_reset", 32'(o_result_ovf), 32'd0);
`ifdef TCAM_HIT_CNT_EN
    check("hit_cnt", o_hit_cnt, 32'd3);
    check("miss_cnt", o_miss_cnt, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
